// File: rtl/calendar_display_scan_pkg.sv
// Shared constants for the calendar display scanner: page encoding, BCD digit values and
// 7-segment patterns. Page state is also the scanner's FSM state.
package calendar_display_scan_pkg;

   localparam int BCD_BIT_WIDTH = 4;

   localparam logic [BCD_BIT_WIDTH-1:0] BCD_0 = 4'd0;
   localparam logic [BCD_BIT_WIDTH-1:0] BCD_1 = 4'd1;
   localparam logic [BCD_BIT_WIDTH-1:0] BCD_2 = 4'd2;
   localparam logic [BCD_BIT_WIDTH-1:0] BCD_3 = 4'd3;
   localparam logic [BCD_BIT_WIDTH-1:0] BCD_4 = 4'd4;
   localparam logic [BCD_BIT_WIDTH-1:0] BCD_5 = 4'd5;
   localparam logic [BCD_BIT_WIDTH-1:0] BCD_6 = 4'd6;
   localparam logic [BCD_BIT_WIDTH-1:0] BCD_7 = 4'd7;
   localparam logic [BCD_BIT_WIDTH-1:0] BCD_8 = 4'd8;
   localparam logic [BCD_BIT_WIDTH-1:0] BCD_9 = 4'd9;

   typedef enum logic [1:0] {
      PAGE_HM = 2'd0,
      PAGE_MS = 2'd1,
      PAGE_MD = 2'd2,
      PAGE_YR = 2'd3
   } page_e;

   localparam logic [7:0] SEG_BLANK = 8'hFF;
   localparam logic [6:0] SEG_DASH  = 7'h3F;

   function automatic page_e next_page(input page_e p);
      return page_e'(p + 2'd1);
   endfunction

endpackage

// File: rtl/calendar_display_scan_bcd_to_seg7.sv
// Combinational BCD to active-low 7-segment decoder ({g,f,e,d,c,b,a}).
// Non-decimal codes 10-15 render as a dash.
module bcd_to_seg7
   import calendar_display_scan_pkg::*;
(
   input  logic [BCD_BIT_WIDTH-1:0] bcd_i,
   output logic [6:0]               seg_o
);

   always_comb begin
      seg_o = SEG_DASH;
      case (bcd_i)
         BCD_0:   seg_o = 7'h40;
         BCD_1:   seg_o = 7'h79;
         BCD_2:   seg_o = 7'h24;
         BCD_3:   seg_o = 7'h30;
         BCD_4:   seg_o = 7'h19;
         BCD_5:   seg_o = 7'h12;
         BCD_6:   seg_o = 7'h02;
         BCD_7:   seg_o = 7'h78;
         BCD_8:   seg_o = 7'h00;
         BCD_9:   seg_o = 7'h10;
         default: seg_o = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/calendar_display_scan.sv
// Time-multiplexed 4-digit common-anode driver for the calendar counter (HH.MM, MM.SS, MO.DD, year).
// Define DISP_AUTO_ROTATE_EN to compile in automatic page rotation every ROTATE_FRAMES frames.
module calendar_display_scan
   import calendar_display_scan_pkg::*;
#(
   parameter int SCAN_DIV      = 25000,
   parameter int ROTATE_FRAMES = 1600
)
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic [BCD_BIT_WIDTH-1:0] sec1,
   input  logic [BCD_BIT_WIDTH-1:0] sec0,
   input  logic [BCD_BIT_WIDTH-1:0] min1,
   input  logic [BCD_BIT_WIDTH-1:0] min0,
   input  logic [BCD_BIT_WIDTH-1:0] hour1,
   input  logic [BCD_BIT_WIDTH-1:0] hour0,
   input  logic [BCD_BIT_WIDTH-1:0] day1,
   input  logic [BCD_BIT_WIDTH-1:0] day0,
   input  logic [BCD_BIT_WIDTH-1:0] month1,
   input  logic [BCD_BIT_WIDTH-1:0] month0,
   input  logic [BCD_BIT_WIDTH-1:0] year2,
   input  logic [BCD_BIT_WIDTH-1:0] year1,
   input  logic [BCD_BIT_WIDTH-1:0] year0,
   input  logic                     page_next,
   output logic [7:0]               seg,
   output logic [3:0]               an,
   output logic [1:0]               page
);

   localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

   if (SCAN_DIV < 2 || ROTATE_FRAMES < 1) begin : g_bad_params
      $error("calendar_display_scan: SCAN_DIV must be >= 2 and ROTATE_FRAMES >= 1");
   end

   logic [DIV_W-1:0]  div_q, div_d;
   logic [1:0]        idx_q, idx_d;
   page_e             page_q, page_d;
   logic              pending_q, pending_d;
   logic              colon_q, colon_d;
   logic [BCD_BIT_WIDTH-1:0] sec0_q;
   // Index 0 = sec0 ... 12 = year2
   logic [12:0][BCD_BIT_WIDTH-1:0] snap_q, snap_d;
   logic [3:0]        an_q, an_d;
   logic [7:0]        seg_q, seg_d;

   logic              tick, boundary, auto_adv, advance;
   logic [BCD_BIT_WIDTH-1:0] digit;
   logic              blank, dp_lit;
   logic [6:0]        glyph;

`ifdef DISP_AUTO_ROTATE_EN
   localparam int FRAME_W = (ROTATE_FRAMES > 1) ? $clog2(ROTATE_FRAMES) : 1;
   localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(ROTATE_FRAMES - 1);

   logic [FRAME_W-1:0] frame_q, frame_d;

   always_comb begin
      auto_adv = boundary && (frame_q == FRAME_LAST);
      frame_d  = frame_q;
      if (page_next) begin
         frame_d = '0;
      end else if (boundary) begin
         frame_d = auto_adv ? '0 : frame_q + FRAME_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) frame_q <= '0;
      else     frame_q <= frame_d;
   end
`else
   assign auto_adv = 1'b0;
`endif

   // Divider, slot index, page FSM, snapshot and colon next-state
   always_comb begin
      tick      = (div_q == DIV_LAST);
      boundary  = tick && (idx_q == 2'd3);
      div_d     = tick ? '0 : div_q + DIV_W'(1);
      idx_d     = tick ? idx_q + 2'd1 : idx_q;
      snap_d    = snap_q;
      page_d    = page_q;
      pending_d = pending_q | page_next;
      advance   = boundary && (pending_q || page_next || auto_adv);
      if (boundary) begin
         snap_d    = {year2, year1, year0, month1, month0, day1, day0,
                      hour1, hour0, min1, min0, sec1, sec0};
         pending_d = 1'b0;
      end
      if (advance) page_d = next_page(page_q);
      colon_d = colon_q ^ (sec0 != sec0_q);
   end

   // Digit selection for the current slot from the frozen snapshot
   always_comb begin
      digit  = '0;
      blank  = 1'b0;
      dp_lit = 1'b0;
      case (page_q)
         PAGE_HM: begin
            digit  = snap_q[2 + idx_q];
            dp_lit = (idx_q == 2'd2) && colon_q;
         end
         PAGE_MS: begin
            digit  = snap_q[idx_q];
            dp_lit = (idx_q == 2'd2);
         end
         PAGE_MD: begin
            digit  = snap_q[6 + idx_q];
            dp_lit = (idx_q == 2'd2);
         end
         default: begin
            if (idx_q == 2'd3) blank = 1'b1;
            else               digit = snap_q[10 + idx_q];
         end
      endcase
   end

   bcd_to_seg7 u_dec (
      .bcd_i (digit),
      .seg_o (glyph)
   );

   always_comb begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = blank ? SEG_BLANK : {~dp_lit, glyph};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         div_q     <= '0;
         idx_q     <= '0;
         page_q    <= PAGE_HM;
         pending_q <= 1'b0;
         snap_q    <= '0;
         colon_q   <= 1'b0;
         sec0_q    <= '0;
         an_q      <= 4'hF;
         seg_q     <= SEG_BLANK;
      end else begin
         div_q     <= div_d;
         idx_q     <= idx_d;
         page_q    <= page_d;
         pending_q <= pending_d;
         snap_q    <= snap_d;
         colon_q   <= colon_d;
         sec0_q    <= sec0;
         an_q      <= an_d;
         seg_q     <= seg_d;
      end
   end

   assign an   = an_q;
   assign seg  = seg_q;
   assign page = page_q;

endmodule

// File: tb/tb_calendar_display_scan.sv
// Directed and randomized checks of calendar_display_scan against a cycle-count based
// reference model of the scan/page/snapshot behaviour.
module tb_calendar_display_scan;

   localparam int SCAN_DIV      = 4;
   localparam int ROTATE_FRAMES = 2;
   localparam int FRAME_CYC     = 4 * SCAN_DIV;

   logic       clk = 1'b0;
   logic       rst;
   logic       page_next;
   logic [3:0] in_d [13];
   logic [7:0] seg;
   logic [3:0] an;
   logic [1:0] page;

   int checks   = 0;
   int failures = 0;

   // Model state: n = cycles since reset release
   int         n;
   int         page_m;
   int         frames_m;
   bit         pend_m;
   bit         colon_m;
   logic [3:0] sec0_prev;
   logic [3:0] snap [13];

   always #5 clk = ~clk;

   calendar_display_scan #(
      .SCAN_DIV      (SCAN_DIV),
      .ROTATE_FRAMES (ROTATE_FRAMES)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .sec1      (in_d[1]),
      .sec0      (in_d[0]),
      .min1      (in_d[3]),
      .min0      (in_d[2]),
      .hour1     (in_d[5]),
      .hour0     (in_d[4]),
      .day1      (in_d[7]),
      .day0      (in_d[6]),
      .month1    (in_d[9]),
      .month0    (in_d[8]),
      .year2     (in_d[12]),
      .year1     (in_d[11]),
      .year0     (in_d[10]),
      .page_next (page_next),
      .seg       (seg),
      .an        (an),
      .page      (page)
   );

   function automatic logic [7:0] code_of(input logic [3:0] d);
      case (d)
         4'd0: return 8'hC0;
         4'd1: return 8'hF9;
         4'd2: return 8'hA4;
         4'd3: return 8'hB0;
         4'd4: return 8'h99;
         4'd5: return 8'h92;
         4'd6: return 8'h82;
         4'd7: return 8'hF8;
         4'd8: return 8'h80;
         4'd9: return 8'h90;
         default: return 8'hBF;
      endcase
   endfunction

   function automatic logic [7:0] model_seg(input int slot);
      int base;
      logic [7:0] s;
      bit dp;
      case (page_m)
         0: base = 2;
         1: base = 0;
         2: base = 6;
         default: base = 10;
      endcase
      if (page_m == 3 && slot == 3) return 8'hFF;
      s  = code_of(snap[base + slot]);
      dp = (slot == 2) && (page_m == 1 || page_m == 2 || (page_m == 0 && colon_m));
      if (dp) s[7] = 1'b0;
      return s;
   endfunction

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s n=%0d observed=%h expected=%h", tag, n, got, exp);
      end
   endtask

   // One clock: predict outputs of the coming edge, advance the model, then compare
   task automatic step();
      logic [3:0] e_an;
      logic [7:0] e_seg;
      int  slot;
      bit  boundary;
      bit  force_adv;
      if (rst) begin
         e_an = 4'hF;
         e_seg = 8'hFF;
         n = 0; page_m = 0; frames_m = 0; pend_m = 0; colon_m = 0;
         sec0_prev = 4'h0;
         for (int i = 0; i < 13; i++) snap[i] = 4'h0;
      end else begin
         slot  = (n / SCAN_DIV) % 4;
         e_an  = ~(4'b0001 << slot);
         e_seg = model_seg(slot);
         if (in_d[0] != sec0_prev) colon_m = ~colon_m;
         sec0_prev = in_d[0];
         boundary = (n % FRAME_CYC) == FRAME_CYC - 1;
`ifdef DISP_AUTO_ROTATE_EN
         force_adv = boundary && (frames_m == ROTATE_FRAMES - 1);
         if (page_next)     frames_m = 0;
         else if (boundary) frames_m = force_adv ? 0 : frames_m + 1;
`else
         force_adv = 1'b0;
`endif
         if (boundary) begin
            for (int i = 0; i < 13; i++) snap[i] = in_d[i];
            if (pend_m || page_next || force_adv) page_m = (page_m + 1) % 4;
            pend_m = 0;
         end else if (page_next) begin
            pend_m = 1;
         end
         n++;
      end
      @(posedge clk);
      #1;
      check("an", {4'h0, an}, {4'h0, e_an});
      check("seg", seg, e_seg);
      check("page", {6'h0, page}, 8'(page_m));
   endtask

   task automatic run(input int cycles);
      for (int i = 0; i < cycles; i++) step();
   endtask

   task automatic pulse_next();
      page_next = 1'b1;
      step();
      page_next = 1'b0;
   endtask

   // Expects to be entered at the first cycle of a frame
   task automatic check_frame(input string tag, input logic [7:0] s3, input logic [7:0] s2,
                              input logic [7:0] s1, input logic [7:0] s0);
      logic [7:0] exp_s [4];
      exp_s = '{s0, s1, s2, s3};
      for (int k = 0; k < 4; k++) begin
         step();
         check({tag, "_an"}, {4'h0, an}, {4'h0, ~(4'b0001 << k)});
         check({tag, "_seg"}, seg, exp_s[k]);
         run(SCAN_DIV - 1);
      end
   endtask

   initial begin
      rst       = 1'b1;
      page_next = 1'b0;
      for (int i = 0; i < 13; i++) in_d[i] = 4'h0;
      n = 0;

      // Reset held for three clocks
      run(3);
      check("rst_an", {4'h0, an}, 8'h0F);
      check("rst_seg", seg, 8'hFF);
      rst = 1'b0;

      // 12:34 loaded during the first frame; first frame still shows zeros
      in_d[5] = 4'd1; in_d[4] = 4'd2; in_d[3] = 4'd3; in_d[2] = 4'd4;
      step();
      check("first_an", {4'h0, an}, 8'h0E);
      check("first_seg", seg, 8'hC0);
      run(FRAME_CYC - 1);
      check_frame("hm", 8'hF9, 8'hA4, 8'hB0, 8'h99);

      // Three page_next pulses inside frame 3 -> a single advance at its end
      step();
      pulse_next();
      run(2);
      pulse_next();
      run(3);
      pulse_next();
      run(47 - n);
`ifndef DISP_AUTO_ROTATE_EN
      check("multi_pulse_hold", {6'h0, page}, 8'd0);
`endif
      step();
`ifndef DISP_AUTO_ROTATE_EN
      check("multi_pulse_step", {6'h0, page}, 8'd1);
`endif

      // Walk to the year page and check the blank leading digit
      in_d[12] = 4'd2; in_d[11] = 4'd0; in_d[10] = 4'd1;
      run(FRAME_CYC);
      run(2);
      pulse_next();
      run(80 - n);
      run(2);
      pulse_next();
      run(96 - n);
`ifndef DISP_AUTO_ROTATE_EN
      check_frame("yr", 8'hFF, 8'hA4, 8'hC0, 8'hF9);
      check("yr_page", {6'h0, page}, 8'd3);
`else
      run(FRAME_CYC);
`endif

      // Mid-frame reset aborts the frame and returns to HH.MM
      run(5);
      rst = 1'b1;
      step();
      check("midrst_an", {4'h0, an}, 8'h0F);
      check("midrst_page", {6'h0, page}, 8'd0);
      rst = 1'b0;

      // Invalid BCD renders as a dash
      in_d[4] = 4'hC;
      run(FRAME_CYC + 2 * SCAN_DIV);
      step();
      check("dash", {1'b0, seg[6:0]}, 8'h3F);

      // Randomized inputs, sec0 flicker, page requests and occasional resets
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(0, 3) == 0) in_d[$urandom_range(0, 12)] = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 7) == 0) in_d[0] = 4'($urandom_range(0, 9));
         page_next = ($urandom_range(0, 23) == 0);
         rst       = ($urandom_range(0, 499) == 0);
         step();
      end
      page_next = 1'b0;
      rst       = 1'b1;
      step();
      rst = 1'b0;

      // Ten frames without page requests
      run(10 * FRAME_CYC);
`ifdef DISP_AUTO_ROTATE_EN
      check("hold_10_frames", {6'h0, page}, 8'd1);
`else
      check("hold_10_frames", {6'h0, page}, 8'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
